// File: rtl/stack_alu_pkg.sv
// stack_alu_pkg: opcode/state encodings and per-op operand counts for stack_alu_core.
// Optional feature macro: STACK_ALU_MUL_EN (makes OpMul a legal opcode).
package stack_alu_pkg;

  typedef enum logic [3:0] {
    OpPush     = 4'd0,
    OpPop      = 4'd1,
    OpDup      = 4'd2,
    OpSwap     = 4'd3,
    OpAdd      = 4'd4,
    OpSub      = 4'd5,
    OpBlt      = 4'd6,
    OpAndshl   = 4'd7,
    OpInc      = 4'd8,
    OpAbs      = 4'd9,
    OpContains = 4'd10,
    OpMul      = 4'd11
  } op_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StMult = 2'd2
  } state_t;

  // Minimum stack depth an opcode needs before it may execute.
  function automatic logic [1:0] op_operands(logic [3:0] op);
    case (op)
      OpPop, OpDup:                           return 2'd1;
      OpSwap, OpAdd, OpSub, OpBlt, OpAndshl,
      OpContains, OpMul:                      return 2'd2;
      default:                                return 2'd0;
    endcase
  endfunction

  function automatic logic op_legal(logic [3:0] op);
`ifdef STACK_ALU_MUL_EN
    return op <= OpMul;
`else
    return op <= OpContains;
`endif
  endfunction

endpackage

// File: rtl/stack_alu_lifo.sv
// stack_alu_lifo: DEPTH x W register stack. Each cycle it pops 0..2 entries, then
// optionally pushes one (pop 1 + push = replace top), or swaps the top two.
module stack_alu_lifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       pop_cnt,
  input  logic             push,
  input  logic             swap,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     s0,
  output logic [W-1:0]     s1,
  output logic [PTR_W-1:0] depth
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] depth_q;
  logic [PTR_W-1:0] base;

  // Slot the pushed word lands in, after any pops of this cycle.
  assign base  = depth_q - PTR_W'(pop_cnt);
  assign depth = depth_q;

  // Depth counter; contents are don't-care after reset so only this is reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) depth_q <= '0;
    else       depth_q <= base + PTR_W'(push);
  end

  // Storage writes: push into the new top slot, or exchange the top two.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && PTR_W'(i) == base) begin
        mem_q[i] <= wdata;
      end else if (swap && PTR_W'(i) == depth_q - PTR_W'(1)) begin
        mem_q[i] <= s1;
      end else if (swap && PTR_W'(i) == depth_q - PTR_W'(2)) begin
        mem_q[i] <= s0;
      end
    end
  end

  // Top-of-stack views, zero when the entry does not exist.
  always_comb begin
    s0 = '0;
    s1 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth_q >= PTR_W'(1) && PTR_W'(i) == depth_q - PTR_W'(1)) s0 = mem_q[i];
      if (depth_q >= PTR_W'(2) && PTR_W'(i) == depth_q - PTR_W'(2)) s1 = mem_q[i];
    end
  end

endmodule

// File: rtl/stack_alu_core.sv
// stack_alu_core: operand-stack ALU with valid/ready command port. Single-cycle ops
// finish at the accept edge; CONTAINS runs a serial window scan in StScan.
// Optional feature macro: STACK_ALU_MUL_EN adds a shift-add MUL (state StMult).
module stack_alu_core
  import stack_alu_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [W-1:0]     cmd_imm,
  input  logic [W-1:0]     reg_val,
  output logic             res_valid,
  output logic [W-1:0]     reg_out,
  output logic             branch_sig,
  output logic             overflow,
  output logic             err_underflow,
  output logic             err_overflow,
  output logic [W-1:0]     s0,
  output logic [W-1:0]     s1,
  output logic [PTR_W-1:0] depth
);

  localparam int unsigned HW  = W / 2;
  localparam int unsigned SHW = $clog2(W);
  localparam int unsigned PW  = $clog2(HW + 1);

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [PW-1:0] p_q, p_d;
  logic [W-1:0]  reg_out_q, reg_out_d;
  logic          branch_q, branch_d;
  logic          ovf_q, ovf_d;
  logic          res_valid_q, res_valid_d;
  logic          err_uf_q, err_uf_d;
  logic          err_of_q, err_of_d;

  logic [1:0]    lf_pop_cnt;
  logic          lf_push, lf_swap;
  logic [W-1:0]  lf_wdata;

  logic          accept;
  op_t           op;
  logic [W:0]    sum;
  logic [W-1:0]  diff, andshl, abs_val;
  logic          most_neg;

`ifdef STACK_ALU_MUL_EN
  localparam int unsigned CW = $clog2(W + 1);
  logic [2*W-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;
`endif

  assign cmd_ready = (state_q == StIdle);
  assign accept    = cmd_valid && cmd_ready;
  assign op        = op_t'(cmd_op);

  assign sum      = {1'b0, s0} + {1'b0, s1};
  assign diff     = s0 - s1;
  assign andshl   = (s0 & s1) << reg_val[SHW-1:0];
  assign most_neg = (reg_val == {1'b1, {(W-1){1'b0}}});
  // Negating the most-negative value wraps back to itself, which is the wanted result.
  assign abs_val  = reg_val[W-1] ? ('0 - reg_val) : reg_val;

  stack_alu_lifo #(
    .W     (W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_lifo (
    .clk     (clk),
    .reset   (reset),
    .pop_cnt (lf_pop_cnt),
    .push    (lf_push),
    .swap    (lf_swap),
    .wdata   (lf_wdata),
    .s0      (s0),
    .s1      (s1),
    .depth   (depth)
  );

  // Command decode, scan/multiply sequencing and stack control.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    p_d         = p_q;
    reg_out_d   = reg_out_q;
    branch_d    = branch_q;
    ovf_d       = ovf_q;
    res_valid_d = 1'b0;
    err_uf_d    = 1'b0;
    err_of_d    = 1'b0;
    lf_pop_cnt  = 2'd0;
    lf_push     = 1'b0;
    lf_swap     = 1'b0;
    lf_wdata    = cmd_imm;
`ifdef STACK_ALU_MUL_EN
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
`endif

    case (state_q)
      StIdle: begin
        if (accept) begin
          res_valid_d = 1'b1;
          if (!op_legal(cmd_op)) begin
            err_of_d = 1'b1;
          end else if (depth < PTR_W'(op_operands(cmd_op))) begin
            err_uf_d = 1'b1;
          end else if ((op == OpPush || op == OpDup) && depth == PTR_W'(DEPTH)) begin
            err_of_d = 1'b1;
          end else begin
            case (op)
              OpPush: lf_push = 1'b1;
              OpPop:  lf_pop_cnt = 2'd1;
              OpDup: begin
                lf_push  = 1'b1;
                lf_wdata = s0;
              end
              OpSwap: lf_swap = 1'b1;
              OpAdd: begin
                lf_pop_cnt = 2'd2;
                lf_push    = 1'b1;
                lf_wdata   = sum[W-1:0];
                ovf_d      = sum[W];
              end
              OpSub: begin
                lf_pop_cnt = 2'd2;
                lf_push    = 1'b1;
                lf_wdata   = diff;
                ovf_d      = (s0 < s1);
              end
              OpBlt: begin
                lf_pop_cnt = 2'd2;
                branch_d   = (s0 < s1);
              end
              OpAndshl: begin
                lf_pop_cnt = 2'd2;
                lf_push    = 1'b1;
                lf_wdata   = andshl;
              end
              OpInc: reg_out_d = reg_val + W'(1);
              OpAbs: begin
                reg_out_d = abs_val;
                ovf_d     = most_neg;
              end
              OpContains: begin
                lf_pop_cnt  = 2'd2;
                a_d         = s0;
                b_d         = s1;
                p_d         = '0;
                res_valid_d = 1'b0;
                state_d     = StScan;
              end
`ifdef STACK_ALU_MUL_EN
              OpMul: begin
                lf_pop_cnt  = 2'd2;
                acc_d       = '0;
                mcand_d     = {{W{1'b0}}, s0};
                mplier_d    = s1;
                cnt_d       = '0;
                res_valid_d = 1'b0;
                state_d     = StMult;
              end
`endif
              default: ;
            endcase
          end
        end
      end

      // a_q shifts right one bit per cycle so its low half is always the window at p_q.
      StScan: begin
        if (a_q[HW-1:0] == b_q[HW-1:0]) begin
          branch_d    = 1'b1;
          res_valid_d = 1'b1;
          state_d     = StIdle;
        end else if (p_q == PW'(HW)) begin
          branch_d    = 1'b0;
          res_valid_d = 1'b1;
          state_d     = StIdle;
        end else begin
          p_d = p_q + PW'(1);
          a_d = a_q >> 1;
        end
      end

`ifdef STACK_ALU_MUL_EN
      // W add/shift steps, then one cycle to push the product.
      StMult: begin
        if (cnt_q == CW'(W)) begin
          lf_push     = 1'b1;
          lf_wdata    = acc_q[W-1:0];
          ovf_d       = |acc_q[2*W-1:W];
          res_valid_d = 1'b1;
          state_d     = StIdle;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
        end
      end
`endif

      default: state_d = StIdle;
    endcase
  end

  // Control and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      p_q         <= '0;
      reg_out_q   <= '0;
      branch_q    <= 1'b0;
      ovf_q       <= 1'b0;
      res_valid_q <= 1'b0;
      err_uf_q    <= 1'b0;
      err_of_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      p_q         <= p_d;
      reg_out_q   <= reg_out_d;
      branch_q    <= branch_d;
      ovf_q       <= ovf_d;
      res_valid_q <= res_valid_d;
      err_uf_q    <= err_uf_d;
      err_of_q    <= err_of_d;
    end
  end

`ifdef STACK_ALU_MUL_EN
  // Multiplier working registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end
`endif

  assign res_valid     = res_valid_q;
  assign reg_out       = reg_out_q;
  assign branch_sig    = branch_q;
  assign overflow      = ovf_q;
  assign err_underflow = err_uf_q;
  assign err_overflow  = err_of_q;

endmodule

// File: tb/tb_stack_alu_core.sv
// tb_stack_alu_core: directed and randomized commands against a queue-based model.
module tb_stack_alu_core;

  localparam int W     = 8;
  localparam int DEPTH = 8;
  localparam int PTR_W = 4;
  localparam int MAX_WAIT = 20;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [3:0]       cmd_op = 4'd0;
  logic [W-1:0]     cmd_imm = '0;
  logic [W-1:0]     reg_val = '0;
  logic             res_valid;
  logic [W-1:0]     reg_out;
  logic             branch_sig;
  logic             overflow;
  logic             err_underflow;
  logic             err_overflow;
  logic [W-1:0]     s0;
  logic [W-1:0]     s1;
  logic [PTR_W-1:0] depth;

  stack_alu_core #(
    .W     (W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_imm       (cmd_imm),
    .reg_val       (reg_val),
    .res_valid     (res_valid),
    .reg_out       (reg_out),
    .branch_sig    (branch_sig),
    .overflow      (overflow),
    .err_underflow (err_underflow),
    .err_overflow  (err_overflow),
    .s0            (s0),
    .s1            (s1),
    .depth         (depth)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: queue back is top of stack.
  int stk[$];
  int m_reg = 0;
  int m_br  = 0;
  int m_ovf = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    stk.delete();
    m_reg = 0;
    m_br  = 0;
    m_ovf = 0;
  endtask

  task automatic model_exec(input int op, input int imm, input int rv,
                            output logic e_uf, output logic e_of, output int e_lat);
    int n, need, a, b, r;
    n = stk.size();
    e_uf = 1'b0;
    e_of = 1'b0;
    e_lat = 0;
    a = 0;
    b = 0;
    case (op)
      1, 2:                need = 1;
      3, 4, 5, 6, 7, 10:   need = 2;
      default:             need = 0;
    endcase
    if (op > 10) begin
      e_of = 1'b1;
    end else if (n < need) begin
      e_uf = 1'b1;
    end else if ((op == 0 || op == 2) && n == DEPTH) begin
      e_of = 1'b1;
    end else begin
      if (need == 2) begin
        a = stk.pop_back();
        b = stk.pop_back();
      end
      case (op)
        0: stk.push_back(imm);
        1: void'(stk.pop_back());
        2: stk.push_back(stk[n-1]);
        3: begin
          stk.push_back(a);
          stk.push_back(b);
        end
        4: begin
          r = a + b;
          stk.push_back(r % 256);
          m_ovf = (r > 255);
        end
        5: begin
          stk.push_back((a - b + 256) % 256);
          m_ovf = (a < b);
        end
        6: m_br = (a < b);
        7: stk.push_back(((a & b) << (rv % 8)) % 256);
        8: m_reg = (rv + 1) % 256;
        9: begin
          r = (rv >= 128) ? 256 - rv : rv;
          m_reg = r % 256;
          m_ovf = (r == 128);
        end
        10: begin
          m_br = 0;
          e_lat = 5;
          for (int p = 0; p <= 4; p++) begin
            if (((a >> p) & 15) == (b & 15)) begin
              m_br = 1;
              e_lat = p + 1;
              break;
            end
          end
        end
        default: ;
      endcase
    end
  endtask

  // Issue one command from a falling edge and check everything at its res_valid cycle.
  task automatic run_cmd(input int op, input int imm, input int rv);
    logic e_uf, e_of;
    int   e_lat, lat, n;
    model_exec(op, imm, rv, e_uf, e_of, e_lat);
    check("ready_before", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op[3:0];
    cmd_imm   = imm[W-1:0];
    reg_val   = rv[W-1:0];
    @(posedge clk);
    @(negedge clk);
    check("ready_after", {31'd0, cmd_ready}, (e_lat == 0) ? 32'd1 : 32'd0);
    // While busy, hold a junk PUSH on the port; it must be ignored.
    cmd_op  = 4'd0;
    cmd_imm = W'($urandom);
    lat = 0;
    while (res_valid !== 1'b1 && lat < MAX_WAIT) begin
      @(negedge clk);
      lat++;
    end
    cmd_valid = 1'b0;
    n = stk.size();
    check("latency", lat, e_lat);
    check("err_uf", {31'd0, err_underflow}, {31'd0, e_uf});
    check("err_of", {31'd0, err_overflow}, {31'd0, e_of});
    check("depth", {28'd0, depth}, n);
    check("s0", {24'd0, s0}, (n >= 1) ? stk[n-1] : 0);
    check("s1", {24'd0, s1}, (n >= 2) ? stk[n-2] : 0);
    check("reg_out", {24'd0, reg_out}, m_reg);
    check("branch", {31'd0, branch_sig}, m_br);
    check("overflow", {31'd0, overflow}, m_ovf);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    int r, op, rv;
    do_reset();

    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_depth", {28'd0, depth}, 32'd0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_reg_out", {24'd0, reg_out}, 32'd0);
    check("rst_flags", {28'd0, branch_sig, overflow, err_underflow, err_overflow}, 32'd0);

    // ADD without and with carry
    run_cmd(0, 76, 0);
    run_cmd(0, 34, 0);
    run_cmd(4, 0, 0);
    check("add_s0", {24'd0, s0}, 32'd110);
    check("add_depth", {28'd0, depth}, 32'd1);
    check("add_ovf", {31'd0, overflow}, 32'd0);
    run_cmd(1, 0, 0);
    run_cmd(0, 128, 0);
    run_cmd(0, 128, 0);
    run_cmd(4, 0, 0);
    check("addc_s0", {24'd0, s0}, 32'd0);
    check("addc_ovf", {31'd0, overflow}, 32'd1);
    run_cmd(1, 0, 0);

    // BLT both ways
    run_cmd(0, 50, 0);
    run_cmd(0, 30, 0);
    run_cmd(6, 0, 0);
    check("blt_taken", {31'd0, branch_sig}, 32'd1);
    check("blt_depth", {28'd0, depth}, 32'd0);
    run_cmd(0, 30, 0);
    run_cmd(0, 50, 0);
    run_cmd(6, 0, 0);
    check("blt_not_taken", {31'd0, branch_sig}, 32'd0);

    // CONTAINS: match at p=0, then no match
    run_cmd(0, 8'h0A, 0);
    run_cmd(0, 8'hAA, 0);
    run_cmd(10, 0, 0);
    check("contains_hit", {31'd0, branch_sig}, 32'd1);
    run_cmd(0, 8'h00, 0);
    run_cmd(0, 8'hAA, 0);
    run_cmd(10, 0, 0);
    check("contains_miss", {31'd0, branch_sig}, 32'd0);

    // Register ops
    run_cmd(9, 0, 8'hFB);
    check("abs_neg", {24'd0, reg_out}, 32'd5);
    run_cmd(9, 0, 8'h80);
    check("abs_minval", {24'd0, reg_out}, 32'h80);
    check("abs_minval_ovf", {31'd0, overflow}, 32'd1);
    run_cmd(8, 0, 8'hFF);
    check("inc_wrap", {24'd0, reg_out}, 32'd0);

    // Underflow on empty, overflow on ninth push
    run_cmd(4, 0, 0);
    check("add_empty_uf", {31'd0, err_underflow}, 32'd1);
    for (int i = 0; i < 9; i++) begin
      run_cmd(0, (i == 6) ? 8'h00 : (i == 7) ? 8'hAA : i * 17 + 3, 0);
    end
    check("push_full_of", {31'd0, err_overflow}, 32'd1);
    check("push_full_depth", {28'd0, depth}, 32'd8);

    // Reset in the middle of a non-matching scan
    cmd_valid = 1'b1;
    cmd_op    = 4'd10;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("scan_busy", {31'd0, cmd_ready}, 32'd0);
    reset = 1'b1;
    #1;
    check("midscan_ready", {31'd0, cmd_ready}, 32'd1);
    check("midscan_depth", {28'd0, depth}, 32'd0);
    check("midscan_res_valid", {31'd0, res_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    check("post_reset_valid", {31'd0, res_valid}, 32'd0);

    // Randomized mix, pushes weighted so the stack sees depth extremes.
    for (int k = 0; k < 400; k++) begin
      r  = $urandom_range(0, 19);
      op = (r < 7) ? 0 : $urandom_range(1, 15);
      r  = $urandom_range(0, 7);
      rv = (r == 0) ? 8'h80 : (r == 1) ? 8'hFF : (r == 2) ? 8'h7F : $urandom_range(0, 255);
      run_cmd(op, $urandom_range(0, 255), rv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_alu_core.md
Name: stack_alu_core

Overview:
- Parametrised successor to the 8-bit stack ALU: operand-stack datapath with internal LIFO of DEPTH words of W bits.
- Commands arrive over a valid/ready handshake. Single-cycle ops complete in one clock; CONTAINS is a serial multi-cycle scan.
- Results are registered. Sits between the instruction decoder and the register file/branch unit of the stack CPU.

Parameters:
- W, 8, datapath/stack word width; must be even and at least 4.
- DEPTH, 8, stack entries; must be at least 2.
- PTR_W, $clog2(DEPTH)+1, width of the depth count.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  core can accept a command.
- cmd_op  in  4  opcode; encoding in package.
- cmd_imm  in  W  immediate for PUSH.
- reg_val  in  W  register operand for INC, ABS and ANDSHL.
- res_valid  out  1  one-cycle pulse: command completed.
- reg_out  out  W  register result.
- branch_sig  out  1  branch/compare result.
- overflow  out  1  carry/borrow/abs-overflow flag.
- err_underflow  out  1  one-cycle pulse with res_valid: too few operands.
- err_overflow  out  1  one-cycle pulse with res_valid: push to full stack, or illegal op.
- s0  out  W  top of stack; 0 when depth<1.
- s1  out  W  next of stack; 0 when depth<2.
- depth  out  PTR_W  number of valid entries.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, depth=0, cmd_ready=1. reg_out, branch_sig, overflow, res_valid and both err pulses are 0. Stack contents are don't-care. Reset aborts any scan in progress.
- Accept occurs on a rising edge with cmd_valid && cmd_ready.
- Single-cycle ops: results, stack and flags update at the accept edge; res_valid is high for exactly the following cycle.
- cmd_ready=1 only in IDLE.
- Ops (a=s0, b=s1; "pop2/push1" means depth-1):
  - PUSH: push cmd_imm.
  - POP: discard s0.
  - DUP: push s0.
  - SWAP: exchange s0 and s1.
  - ADD: pop2/push1 (a+b) mod 2^W; overflow = carry-out.
  - SUB: pop2/push1 (a-b) mod 2^W; overflow = borrow (a<b).
  - BLT: pop2; branch_sig = a<b, unsigned.
  - ANDSHL: pop2/push1 (a&b)<<reg_val[$clog2(W)-1:0]; zero-fill.
  - INC: reg_out = reg_val+1, wraps.
  - ABS: reg_out = |reg_val| as signed. For reg_val = most-negative value, reg_out = reg_val and overflow=1; otherwise overflow=0.
  - CONTAINS: pop2; branch_sig=1 iff the pattern b[W/2-1:0] equals a[p+W/2-1:p] for some p in 0..W/2.
- Flags are held unless the op defines them.
- Operand requirements: POP, DUP and CONTAINS need depth>=1 (CONTAINS needs 2). SWAP, ADD, SUB, BLT and ANDSHL need depth>=2.
- Error cases:
  - Too few operands: stack and flags unchanged; err_underflow pulses with res_valid.
  - PUSH or DUP with depth==DEPTH: unchanged; err_overflow pulses.
  - Illegal opcode: unchanged; err_overflow pulses.
- FSM:
  - IDLE -> SCAN on accepted CONTAINS with depth>=2. Operands are latched and popped at the accept edge.
  - SCAN tests position p (starts at 0) each cycle.
    - On a match: branch_sig=1, go to IDLE.
    - At p=W/2 with no match: branch_sig=0, go to IDLE.
    - Otherwise p++.
  - res_valid pulses the cycle after leaving SCAN.
  - Latency: match at p gives res_valid p+1 cycles after accept; worst case W/2+1.
  - MULT: present only with the optional feature.
- cmd_valid while cmd_ready=0 is ignored, not queued.

Optional Feature:
- Macro STACK_ALU_MUL_EN.
- Defined: op MUL uses a shift-add multiplier, one bit per cycle, in state MULT. It pops a,b and pushes the low W bits of a*b. overflow=1 iff the high W bits are nonzero. res_valid comes W+1 cycles after accept. Underflow rules as ADD.
- Undefined: MUL opcode is illegal (err_overflow pulse); MULT state and multiplier logic are absent.

Decomposition:
- Package stack_alu_pkg: op_t enum (PUSH, POP, DUP, SWAP, ADD, SUB, BLT, ANDSHL, INC, ABS, CONTAINS, MUL), state_t enum (IDLE, SCAN, MULT), and an operand-count-per-op function.
- Sub-module stack_alu_lifo: parametrised W/DEPTH register stack. Interface: push/pop/replace-top, s0/s1/depth outputs, async reset of depth.

Test Plan:
- PUSH 76, PUSH 34, ADD -> s0=110, depth=1, overflow=0. Then PUSH 128, PUSH 128, ADD -> s0=0, overflow=1.
- PUSH 50, PUSH 30, BLT -> branch_sig=1, depth=0. PUSH 30, PUSH 50, BLT -> branch_sig=0.
- PUSH 8'h0A, PUSH 8'hAA, CONTAINS -> cmd_ready=0 for 1 cycle; res_valid 1 cycle after accept; branch_sig=1.
- PUSH 8'h00, PUSH 8'hAA, CONTAINS -> res_valid 5 cycles after accept; branch_sig=0.
- ABS with reg_val=8'hFB -> reg_out=5. ABS with 8'h80 -> reg_out=8'h80, overflow=1. INC with 8'hFF -> reg_out=0.
- ADD on empty stack -> err_underflow=1, depth=0. Nine PUSHes with DEPTH=8 -> ninth gives err_overflow, depth=8.
- Reset asserted mid-SCAN -> cmd_ready=1, depth=0, res_valid=0 immediately.
